cdc_tx_queue: RTL and testbench

Clock-domain-A transmit queue that sits directly upstream of the multi-cycle-path CDC synchroniser. It buffers up to `depth` words written by a domain-A producer and drains them one at a time into the synchroniser's send/ready handshake. This decouples bursty producers from the multi-cycle round trip of each crossing.

---
 rtl/cdc_tx_queue_if.sv | 29 ++
 rtl/cdc_tx_queue.sv | 79 +++++++
 tb/tb_cdc_tx_queue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cdc_tx_queue_if.sv
// Producer / synchroniser-facing bundle for cdc_tx_queue.
// slave = the queue itself, master = the domain-A producer and synchroniser side.
interface cdc_tx_queue_if #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
);
    localparam int unsigned level_w = $clog2(depth + 1);

    logic               wr_en;
    logic [width-1:0]   wr_data;
    logic               full;
    logic               empty;
    logic [level_w-1:0] level;
    logic               mcp_ready;
    logic               mcp_send;
    logic [width-1:0]   mcp_data;
    logic               overflow;
    logic               overflow_clr;

    modport master (
        output wr_en, wr_data, mcp_ready, overflow_clr,
        input  full, empty, level, mcp_send, mcp_data, overflow
    );

    modport slave (
        input  wr_en, wr_data, mcp_ready, overflow_clr,
        output full, empty, level, mcp_send, mcp_data, overflow
    );
endinterface

// File: rtl/cdc_tx_queue.sv
// Domain-A transmit queue feeding the multi-cycle-path synchroniser's send/ready handshake.
// Define CDC_TXQ_OVERFLOW_EN to build the sticky write-while-full overflow flag.
module cdc_tx_queue #(
    parameter int unsigned      width     = 8,
    parameter int unsigned      depth     = 4,
    parameter logic [width-1:0] reset_val = '0
) (
    input logic           clk_a,
    input logic           reset,
    cdc_tx_queue_if.slave bus
);
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = $clog2(depth + 1);

    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic [width-1:0] mem [depth];

    logic full_c;
    logic empty_c;
    logic send_c;
    logic push;
    logic pop;

    // Flags decode the registered count only, so they move on edges or reset.
    assign full_c  = (count == cnt_w'(depth));
    assign empty_c = (count == cnt_w'(0));
    assign send_c  = ~empty_c & bus.mcp_ready;
    assign push    = bus.wr_en & ~full_c;
    assign pop     = send_c;

    assign bus.full     = full_c;
    assign bus.empty    = empty_c;
    assign bus.level    = count;
    assign bus.mcp_send = send_c;
    assign bus.mcp_data = mem[rd_ptr];

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk_a or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_w'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
            if (push && !pop)      count <= count + cnt_w'(1);
            else if (pop && !push) count <= count - cnt_w'(1);
        end
    end

    // Storage; a full-cycle write cannot land in the slot being popped the same edge.
    always_ff @(posedge clk_a or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(depth); i++) mem[i] <= reset_val;
        end else if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

`ifdef CDC_TXQ_OVERFLOW_EN
    logic overflow_q;

    // Sticky drop indicator; a coincident set beats the clear.
    always_ff @(posedge clk_a or posedge reset) begin
        if (reset)                  overflow_q <= 1'b0;
        else if (bus.wr_en && full_c) overflow_q <= 1'b1;
        else if (bus.overflow_clr)  overflow_q <= 1'b0;
    end

    assign bus.overflow = overflow_q;
`else
    logic unused_overflow_clr;

    assign unused_overflow_clr = bus.overflow_clr;
    assign bus.overflow        = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_tx_queue.sv
// Directed self-checking bench for cdc_tx_queue (depth 4, width 8).
module tb_cdc_tx_queue;
    logic clk_a = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cdc_tx_queue_if #(.width(8), .depth(4)) bus ();

    cdc_tx_queue #(.width(8), .depth(4), .reset_val(8'h00)) dut (
        .clk_a (clk_a),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_a = ~clk_a;

`ifdef CDC_TXQ_OVERFLOW_EN
    localparam logic ovf_on = 1'b1;
`else
    localparam logic ovf_on = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and move just past it; inputs change only here.
    task automatic cyc();
        @(posedge clk_a);
        #1;
    endtask

    task automatic write_idle(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        cyc();
        bus.wr_en   = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en        = 1'b0;
        bus.wr_data      = 8'h00;
        bus.mcp_ready    = 1'b0;
        bus.overflow_clr = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_send", 32'(bus.mcp_send), 32'd0);
        chk("rst_data", 32'(bus.mcp_data), 32'h00);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);

        // Single word with ready high: offered the cycle after the write edge.
        bus.mcp_ready = 1'b1;
        #1;
        chk("empty_no_send", 32'(bus.mcp_send), 32'd0);
        write_idle(8'hA5);
        chk("single_send", 32'(bus.mcp_send), 32'd1);
        chk("single_data", 32'(bus.mcp_data), 32'hA5);
        chk("single_level", 32'(bus.level), 32'd1);
        cyc();
        cyc();
        chk("single_empty", 32'(bus.empty), 32'd1);
        chk("single_send_off", 32'(bus.mcp_send), 32'd0);

        // Fill with ready low.
        bus.mcp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) write_idle(8'(i));
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_level", 32'(bus.level), 32'd4);
        chk("fill_no_send", 32'(bus.mcp_send), 32'd0);
        chk("fill_head", 32'(bus.mcp_data), 32'h01);

        // Write while full is dropped.
        write_idle(8'hFF);
        chk("ovf_level", 32'(bus.level), 32'd4);
        chk("ovf_flag", 32'(bus.overflow), 32'(ovf_on));
        cyc();
        chk("ovf_sticky", 32'(bus.overflow), 32'(ovf_on));
        bus.wr_en        = 1'b1;
        bus.wr_data      = 8'hFF;
        bus.overflow_clr = 1'b1;
        cyc();
        bus.wr_en = 1'b0;
        #1;
        chk("ovf_set_wins", 32'(bus.overflow), 32'(ovf_on));
        cyc();
        bus.overflow_clr = 1'b0;
        #1;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        chk("ovf_level2", 32'(bus.level), 32'd4);

        // Drain with ready pulses; order 01..04, no FF.
        for (int k = 0; k < 4; k++) begin
            bus.mcp_ready = 1'b1;
            #1;
            chk("drain_send", 32'(bus.mcp_send), 32'd1);
            chk("drain_data", 32'(bus.mcp_data), 32'(k + 1));
            cyc();
            bus.mcp_ready = 1'b0;
            #1;
            chk("drain_idle", 32'(bus.mcp_send), 32'd0);
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_level", 32'(bus.level), 32'd0);

        // Simultaneous push/pop at level 2; pointers wrap past 3.
        write_idle(8'h10);
        write_idle(8'h11);
        bus.mcp_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h12 + j);
            #1;
            chk("pp_level", 32'(bus.level), 32'd2);
            chk("pp_data", 32'(bus.mcp_data), 32'(8'h10 + j));
            chk("pp_send", 32'(bus.mcp_send), 32'd1);
            cyc();
        end
        bus.wr_en = 1'b0;
        #1;
        chk("pp_level_end", 32'(bus.level), 32'd2);
        chk("pp_tail0", 32'(bus.mcp_data), 32'h16);
        cyc();
        chk("pp_tail1", 32'(bus.mcp_data), 32'h17);
        cyc();
        chk("pp_empty", 32'(bus.empty), 32'd1);

        // Full with ready: the pop frees a slot only next cycle, so EE is dropped.
        bus.mcp_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_idle(8'(8'h20 + i));
        bus.mcp_ready = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_data   = 8'hEE;
        #1;
        chk("fr_send", 32'(bus.mcp_send), 32'd1);
        chk("fr_data", 32'(bus.mcp_data), 32'h20);
        cyc();
        bus.wr_en = 1'b0;
        #1;
        chk("fr_level", 32'(bus.level), 32'd3);
        chk("fr_ovf", 32'(bus.overflow), 32'(ovf_on));
        for (int k = 1; k < 4; k++) begin
            chk("fr_data_seq", 32'(bus.mcp_data), 32'(8'h20 + k));
            cyc();
        end
        chk("fr_empty", 32'(bus.empty), 32'd1);
        chk("fr_no_ee", 32'(bus.mcp_send), 32'd0);

        // Asynchronous reset between edges with words queued.
        bus.mcp_ready = 1'b0;
        write_idle(8'h30);
        write_idle(8'h31);
        chk("ar_pre_level", 32'(bus.level), 32'd2);
        bus.mcp_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("ar_empty", 32'(bus.empty), 32'd1);
        chk("ar_level", 32'(bus.level), 32'd0);
        chk("ar_send", 32'(bus.mcp_send), 32'd0);
        chk("ar_data", 32'(bus.mcp_data), 32'h00);
        chk("ar_ovf", 32'(bus.overflow), 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("ar_post_empty", 32'(bus.empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
